jamma_joy_scanner: RTL
======================

// Module: jamma_joy_scanner
// PURPOSE
// - Time-multiplexed JAMMA control scanner, replacing the fixed 2-player JSELECT toggle in the arcade tops.
// - Drives a player-select bus and waits a settle time after each select change.
// - Samples the shared active-low 8-bit JJOY bus into per-player registers.
// - Optionally debounces each bit; outputs feed core I_JOYSTICK_x / I_PLAYER.
// PARAMETERS
// - NUM_PLAYERS  2  players scanned, 1..4
// - JOY_W        8  bits per player (active-low)
// - SETTLE       1  cycles held after select change before sampling, >=1
// - DEB_SAMPLES  4  consecutive equal samples needed to change a debounced bit, 1..15
// - SEL_W        derived = (NUM_PLAYERS<=2) ? 1 : 2
// PORTS
// - pclk       in   1                    pixel clock, sole clock domain
// - reset      in   1                    synchronous, active-high
// - joy_in     in   JOY_W                multiplexed JJOY bus, active-low
// - local_joy  in   JOY_W                on-board joystick, ANDed into player 0 only
// - hold       in   1                    1 = freeze scan; outputs keep last values
// - joy_sel    out  SEL_W                player select driven to cabinet (JSELECT)
// - joy_out    out  NUM_PLAYERS*JOY_W    player p at [p*JOY_W +: JOY_W], active-low
// - scan_done  out  1                    1-cycle pulse when the last player has been sampled
// BEHAVIOUR
// - Reset values: joy_sel=0, joy_out all 1s (released), scan_done=0, FSM=SETTLE, cnt=0, debounce counters=0.
// - FSM SETTLE: cnt increments each cycle; when cnt==SETTLE-1, next state is SAMPLE.
// - FSM SAMPLE, single cycle:
//   - Capture joy_in (for p==0: joy_in & local_joy) into slot joy_sel.
//   - Update joy_sel to joy_sel+1, wrapping NUM_PLAYERS-1 -> 0; clear cnt; next state SETTLE.
// - Period per player is SETTLE+1 cycles; full scan is NUM_PLAYERS*(SETTLE+1) cycles.
// - Capture latency: value on joy_in in the SAMPLE cycle appears on joy_out the next cycle (no debounce).
// - scan_done is registered, high the cycle after SAMPLE of player NUM_PLAYERS-1, else 0.
// - NUM_PLAYERS==1: joy_sel stays 0, scan_done pulses every SETTLE+1 cycles.
// - hold=1:
//   - State, cnt, joy_sel and debounce counters frozen; no capture; scan_done forced 0.
//   - Release resumes exactly where it stopped.
// - hold and reset both high: reset wins.
// - Reset asserted mid-scan: all state returns to reset values at the next edge. No partial slot update.
// - Only the slot addressed by joy_sel changes in a given cycle; other slots are untouched.
// CONFIGURATION
// - Macro JAMMA_JOY_DEBOUNCE_EN defined:
//   - Per bit, a 4-bit counter runs per player.
//   - On SAMPLE: if the sampled bit equals the current joy_out bit, clear the counter.
//   - Otherwise increment it. When the counter reaches DEB_SAMPLES, flip the output bit and clear the counter.
//   - With DEB_SAMPLES=1 the response equals the undebounced path.
//   - Counters hold while hold=1 and clear on reset.
// - Macro undefined: no counters are synthesised; joy_out slot loads the raw sample directly.
// TESTING
// - Reset, NUM_PLAYERS=2, SETTLE=1, joy_in=8'hFF -> joy_sel toggles every 2 cycles, joy_out=16'hFFFF, scan_done every 4 cycles.
// - Drive joy_in=8'hFE only while joy_sel=1, local_joy=8'hFF -> joy_out[15:8]=8'hFE, joy_out[7:0]=8'hFF one cycle after sample.
// - local_joy=8'hF7, joy_in=8'hFF -> joy_out[7:0]=8'hF7, joy_out[15:8]=8'hFF.
// - Assert hold 10 cycles mid-SETTLE -> joy_sel and joy_out constant, scan_done=0; phase continues unchanged after release.
// - NUM_PLAYERS=4, SETTLE=3 -> joy_sel sequence 0,1,2,3,0 with 4 cycles each; scan_done once per 16 cycles; reset mid-scan -> joy_sel=0, joy_out all 1s.
// - DEBOUNCE_EN, DEB_SAMPLES=4: bit0 low for 3 player-0 samples then high -> joy_out[0] stays 1; low for 4 samples -> 0 after the 4th.

Source files
------------

// File: rtl/jamma_joy_scanner.sv
// jamma_joy_scanner: time-multiplexed JAMMA control scanner.
// Steps a player-select bus, waits SETTLE cycles after each select change,
// then samples the shared active-low JJOY bus into that player's slot.
// Optional per-bit debounce is enabled with the macro JAMMA_JOY_DEBOUNCE_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SETTLE | select just changed; count cycles until the bus has settled
// ST_SAMPLE | one cycle: capture bus into slot joy_sel, advance joy_sel
module jamma_joy_scanner #(
  parameter int NUM_PLAYERS = 2,
  parameter int JOY_W       = 8,
  parameter int SETTLE      = 1,
  parameter int DEB_SAMPLES = 4,
  localparam int SEL_W      = (NUM_PLAYERS <= 2) ? 1 : 2
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic [JOY_W-1:0]             joy_in,
  input  logic [JOY_W-1:0]             local_joy,
  input  logic                         hold,
  output logic [SEL_W-1:0]             joy_sel,
  output logic [NUM_PLAYERS*JOY_W-1:0] joy_out,
  output logic                         scan_done
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int OUT_W = NUM_PLAYERS * JOY_W;

  // Reject parameter sets the scanner cannot represent.
  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
    $error("jamma_joy_scanner: NUM_PLAYERS must be 1..4");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("jamma_joy_scanner: SETTLE must be >= 1");
  end
  if (DEB_SAMPLES < 1 || DEB_SAMPLES > 15) begin : g_bad_deb
    $error("jamma_joy_scanner: DEB_SAMPLES must be 1..15");
  end

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               done_q, done_d;
  logic [JOY_W-1:0]   sample;

`ifdef JAMMA_JOY_DEBOUNCE_EN
  logic [OUT_W-1:0][3:0] deb_q, deb_d;
`endif

  // The on-board joystick only ever merges into player 0.
  always_comb begin
    sample = joy_in;
    if (sel_q == '0) sample = joy_in & local_joy;
  end

  // Scan sequencing: settle counter, sample cycle, select advance and done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    if (!hold) begin
      case (state_q)
        ST_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE - 1)) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
          if (sel_q == SEL_W'(NUM_PLAYERS - 1)) begin
            done_d = 1'b1;
            sel_d  = '0;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  // Slot update: only the slot addressed by the current select may change.
  always_comb begin
    out_d = out_q;
`ifdef JAMMA_JOY_DEBOUNCE_EN
    deb_d = deb_q;
`endif
    if (!hold && state_q == ST_SAMPLE) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (sel_q == SEL_W'(p)) begin
`ifdef JAMMA_JOY_DEBOUNCE_EN
          for (int b = 0; b < JOY_W; b++) begin
            if (sample[b] == out_q[p*JOY_W + b]) begin
              deb_d[p*JOY_W + b] = 4'd0;
            end else if (deb_q[p*JOY_W + b] + 4'd1 == 4'(DEB_SAMPLES)) begin
              // Enough consecutive disagreeing samples: accept the new level.
              out_d[p*JOY_W + b] = ~out_q[p*JOY_W + b];
              deb_d[p*JOY_W + b] = 4'd0;
            end else begin
              deb_d[p*JOY_W + b] = deb_q[p*JOY_W + b] + 4'd1;
            end
          end
`else
          out_d[p*JOY_W +: JOY_W] = sample;
`endif
        end
      end
    end
  end

  // All state registers; reset has priority over hold.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      out_q   <= '1;
      done_q  <= 1'b0;
`ifdef JAMMA_JOY_DEBOUNCE_EN
      deb_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef JAMMA_JOY_DEBOUNCE_EN
      deb_q   <= deb_d;
`endif
    end
  end

  assign joy_sel   = sel_q;
  assign joy_out   = out_q;
  assign scan_done = done_q;

endmodule
